hq_energy_selector: RTL and testbench
=====================================

Name: hq_energy_selector

Overview:
- Sits directly downstream of the Hq matrix multiplier.
- Consumes the serial stream of 16 complex 4x2 Hq matrices (8 elements each, 128 elements total).
- Computes the Frobenius energy of each matrix and selects the matrix with the largest energy.
- Buffers the selected matrix and streams it to the detector stage over a valid/ready handshake.

Parameters:
- N, 16, signed width of each real/imag sample (Q-format).
- Q, 8, fractional bits; informational only, no rescaling is performed.
- ACC_WIDTH, 36, energy accumulator width; must be >= 2N+4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; high for the whole job, low returns the block to idle
- hq_in_valid  in  1  one Hq element present this cycle
- hq_in_r  in  N  signed real part of element
- hq_in_i  in  N  signed imaginary part of element
- out_ready  in  1  downstream accepts the current output element
- out_valid  out  1  output element valid
- out_r  out  N  real part of best-matrix element
- out_i  out  N  imaginary part of best-matrix element
- out_last  out  1  high with the 8th output element
- best_q  out  4  index of the selected matrix
- best_energy  out  ACC_WIDTH  energy of the selected matrix
- select_done  out  1  level, job complete

Behaviour:
- Reset: every output is 0; state S_IDLE; all counters, the accumulator and the bank pointers are 0.
- Input element order within a matrix: row-major, index = 2*i + j (i = 0..3, j = 0..1). Matrices arrive in order q = 0..15.
- No input backpressure exists. hq_in_valid is accepted in every cycle of S_ACCUM, back-to-back included.
- hq_in_valid in any other state is ignored.
- States:
  - S_IDLE: clear counters and accumulator. Go to S_ACCUM when start = 1.
  - S_ACCUM: on each valid element:
    - e = r*r + i*i, computed full precision and unsigned (max 2^31).
    - Write the element to buffer bank wr_bank at address elem_cnt.
    - Increment elem_cnt (3 bits, wraps 7 -> 0).
  - On the 8th element of a matrix, all on the same edge:
    - total = acc + e, combinationally.
    - If q_cnt == 0 or total > best_energy (strictly greater): best_energy <= total, best_q <= q_cnt, best_bank <= wr_bank, wr_bank <= ~wr_bank.
    - Otherwise wr_bank is unchanged and is overwritten by the next matrix.
    - acc <= 0. q_cnt increments (4 bits).
  - Ties therefore keep the lowest q.
  - best_q and best_energy are visible the cycle after the 8th element's edge.
  - A next-matrix element arriving in that cycle is written to the correct bank.
  - After the 128th element (q_cnt wraps 15 -> 0), go to S_OUT.
  - S_OUT: out_valid = 1 and out_r/out_i = best_bank[rd_cnt].
    - rd_cnt advances only when out_valid && out_ready.
    - Outputs are held stable while out_ready = 0.
    - out_last = 1 when rd_cnt == 7.
    - After the 8th handshake, go to S_DONE with out_valid = 0.
  - S_DONE: select_done = 1; best_q and best_energy are held. Go to S_IDLE when start = 0.
  - start dropping in S_ACCUM or S_OUT aborts the job: go to S_IDLE, out_valid <= 0, best_q and best_energy hold their last values.
- Re-entering S_ACCUM from S_IDLE clears best_q and best_energy to 0.
- The accumulator never overflows for ACC_WIDTH >= 2N+4, so no saturation logic is needed.
- Registered outputs; out_* are driven from registers or the buffer read mux with no combinational path from out_ready to out_r/out_i.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous).
- Buffer: 2 banks x 8 entries x 2N bits, implemented as flops.

Test Plan:
- All 128 elements = (256, 0), except matrix 5 = (512, 0):
  - best_q = 5, best_energy = 2097152.
  - Output is 8 x (512, 0), out_last on the 8th, then select_done = 1.
- All elements = (256, -256) in every matrix -> best_q = 0, best_energy = 1048576 (tie keeps lowest).
- Matrix 15 elements = (-32768, -32768), others = (1, 1):
  - best_q = 15, best_energy = 17179869184.
  - Output streams (-32768, -32768) with no overflow.
- Back-to-back hq_in_valid for all 128 elements, with matrix 3 best and matrix 4 arriving the cycle after matrix 3's last element -> matrix 3 data intact in the output stream.
- During S_OUT, toggle out_ready as 1,0,0,1,0,1,... -> exactly 8 handshakes in index order, data stable while stalled, single out_last.
- Assert rst after 40 elements:
  - All outputs go to 0 immediately.
  - A full rerun produces correct results.
  - With start = 0 and hq_in_valid pulsed, nothing is accumulated.

Source files
------------

// File: rtl/hq_energy_selector_if.sv
// Stream interface between the Hq multiplier, the energy selector and the detector.
// The selector is the slave side: it consumes Hq elements and produces the best matrix.
interface hq_energy_selector_if #(
    parameter int N         = 16,
    parameter int ACC_WIDTH = 36
);
    logic                   start;
    logic                   hq_in_valid;
    logic signed [N-1:0]    hq_in_r;
    logic signed [N-1:0]    hq_in_i;
    logic                   out_ready;
    logic                   out_valid;
    logic signed [N-1:0]    out_r;
    logic signed [N-1:0]    out_i;
    logic                   out_last;
    logic [3:0]             best_q;
    logic [ACC_WIDTH-1:0]   best_energy;
    logic                   select_done;

    modport master (
        output start, hq_in_valid, hq_in_r, hq_in_i, out_ready,
        input  out_valid, out_r, out_i, out_last, best_q, best_energy, select_done
    );

    modport slave (
        input  start, hq_in_valid, hq_in_r, hq_in_i, out_ready,
        output out_valid, out_r, out_i, out_last, best_q, best_energy, select_done
    );
endinterface

// File: rtl/hq_energy_selector.sv
// Selects the Hq matrix with the largest Frobenius energy out of 16 serial 4x2
// complex matrices, buffers it in a ping-pong bank and streams it downstream.
module hq_energy_selector #(
    parameter int N         = 16,
    parameter int Q         = 8,
    parameter int ACC_WIDTH = 36
) (
    input  logic               clk,
    input  logic               rst,
    hq_energy_selector_if.slave bus
);
    // Q is informational; reject nonsensical widths at elaboration.
    if (ACC_WIDTH < 2 * N + 4 || Q >= N) begin : g_bad_param
        $error("hq_energy_selector: ACC_WIDTH must be >= 2N+4 and Q < N");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT, S_DONE} state_t;

    state_t                 state, state_nx;
    logic [2:0]             elem_cnt, rd_cnt;
    logic [3:0]             q_cnt, best_q;
    logic [ACC_WIDTH-1:0]   acc, best_energy, elem_e, total;
    logic                   wr_bank, best_bank;
    logic                   out_valid, out_last, select_done;
    logic                   accept, last_elem, take_best, hs;
    logic [2*N-1:0]         bank_mem [2][8];
    logic [2*N-1:0]         rd_word;

    // Full-precision unsigned energy of one complex element: r*r + i*i.
    function automatic logic [ACC_WIDTH-1:0] elem_energy(input logic signed [N-1:0] r,
                                                         input logic signed [N-1:0] i);
        logic signed [ACC_WIDTH-1:0] r_x, i_x;
        r_x = {{(ACC_WIDTH-N){r[N-1]}}, r};
        i_x = {{(ACC_WIDTH-N){i[N-1]}}, i};
        return $unsigned(r_x * r_x + i_x * i_x);
    endfunction

    assign accept    = (state == S_ACCUM) && bus.start && bus.hq_in_valid;
    assign elem_e    = elem_energy(bus.hq_in_r, bus.hq_in_i);
    assign total     = acc + elem_e;
    assign last_elem = accept && (elem_cnt == 3'd7);
    assign take_best = last_elem && ((q_cnt == 4'd0) || (total > best_energy));
    assign hs        = out_valid && bus.out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; dropping start aborts any active job.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_ACCUM;
            S_ACCUM: begin
                if (!bus.start)                        state_nx = S_IDLE;
                else if (last_elem && q_cnt == 4'd15)  state_nx = S_OUT;
            end
            S_OUT: begin
                if (!bus.start)                        state_nx = S_IDLE;
                else if (hs && rd_cnt == 3'd7)         state_nx = S_DONE;
            end
            S_DONE:  if (!bus.start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Counters, energy accumulation, best-matrix tracking and output flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt    <= '0;
            rd_cnt      <= '0;
            q_cnt       <= '0;
            acc         <= '0;
            best_q      <= '0;
            best_energy <= '0;
            wr_bank     <= 1'b0;
            best_bank   <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            select_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    elem_cnt <= '0;
                    rd_cnt   <= '0;
                    q_cnt    <= '0;
                    acc      <= '0;
                    wr_bank  <= 1'b0;
                    if (bus.start) begin
                        best_q      <= '0;
                        best_energy <= '0;
                    end
                end
                S_ACCUM: begin
                    rd_cnt <= '0;
                    if (accept) begin
                        elem_cnt <= elem_cnt + 3'd1;
                        if (elem_cnt == 3'd7) begin
                            acc   <= '0;
                            q_cnt <= q_cnt + 4'd1;
                            // Winner's bank is frozen; a loser's bank is simply reused.
                            if (take_best) begin
                                best_energy <= total;
                                best_q      <= q_cnt;
                                best_bank   <= wr_bank;
                                wr_bank     <= ~wr_bank;
                            end
                        end else begin
                            acc <= total;
                        end
                    end
                end
                S_OUT:   if (hs) rd_cnt <= rd_cnt + 3'd1;
                default: ;
            endcase
            out_valid   <= (state_nx == S_OUT);
            out_last    <= (state_nx == S_OUT) && (state == S_OUT) &&
                           (hs ? (rd_cnt == 3'd6) : (rd_cnt == 3'd7));
            select_done <= (state_nx == S_DONE);
        end
    end

    // Element buffer: two banks of eight {r, i} words, data only, no reset.
    always_ff @(posedge clk) begin
        if (accept) bank_mem[wr_bank][elem_cnt] <= {bus.hq_in_r, bus.hq_in_i};
    end

    assign rd_word         = bank_mem[best_bank][rd_cnt];
    assign bus.out_r       = out_valid ? rd_word[2*N-1:N] : '0;
    assign bus.out_i       = out_valid ? rd_word[N-1:0]   : '0;
    assign bus.out_valid   = out_valid;
    assign bus.out_last    = out_last;
    assign bus.best_q      = best_q;
    assign bus.best_energy = best_energy;
    assign bus.select_done = select_done;
endmodule

// File: tb/tb_hq_energy_selector.sv
// Testbench for hq_energy_selector: directed and randomized jobs compared with
// a reference model that ranks matrices by their summed element energies.
module tb_hq_energy_selector;
    localparam int N         = 16;
    localparam int ACC_WIDTH = 36;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hq_energy_selector_if #(.N(N), .ACC_WIDTH(ACC_WIDTH)) bus();

    hq_energy_selector #(.N(N), .Q(8), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int                  n_chk  = 0;
    int                  n_pass = 0;
    logic signed [N-1:0] mr [128];
    logic signed [N-1:0] mi [128];
    int                  exp_q;
    longint              exp_e;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: best matrix among the first nmat, strict > so ties keep the lowest index.
    task automatic ref_best(input int nmat);
        longint e;
        exp_q = 0;
        exp_e = -1;
        for (int q = 0; q < nmat; q++) begin
            e = 0;
            for (int k = 0; k < 8; k++)
                e += longint'(mr[q*8+k]) * longint'(mr[q*8+k]) +
                     longint'(mi[q*8+k]) * longint'(mi[q*8+k]);
            if (e > exp_e) begin
                exp_e = e;
                exp_q = q;
            end
        end
    endtask

    task automatic fill_const(input int r, input int i);
        for (int k = 0; k < 128; k++) begin
            mr[k] = N'(r);
            mi[k] = N'(i);
        end
    endtask

    task automatic fill_matrix(input int q, input int r, input int i);
        for (int k = 0; k < 8; k++) begin
            mr[q*8+k] = N'(r);
            mi[q*8+k] = N'(i);
        end
    endtask

    // gap: random idle cycles between elements; rmode: 0 ready, 1 fixed toggle pattern, 2 random.
    task automatic run_job(input int gap, input int rmode);
        int  idx;
        int  pat [6] = '{1, 0, 0, 1, 0, 1};
        logic rdy;
        ref_best(16);
        bus.start = 1'b1;
        step();
        for (int k = 0; k < 128; k++) begin
            if (gap != 0) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.hq_in_valid = 1'b0;
                    bus.hq_in_r     = N'($urandom);
                    bus.hq_in_i     = N'($urandom);
                    step();
                end
            end
            bus.hq_in_valid = 1'b1;
            bus.hq_in_r     = mr[k];
            bus.hq_in_i     = mi[k];
            step();
        end
        bus.hq_in_valid = 1'b0;
        chk("best_q", longint'(bus.best_q), longint'(exp_q));
        chk("best_energy", longint'(bus.best_energy), exp_e);
        idx = 0;
        for (int c = 0; c < 300 && idx < 8; c++) begin
            if (rmode == 0)      rdy = 1'b1;
            else if (rmode == 1) rdy = pat[c % 6] != 0;
            else                 rdy = 1'($urandom_range(0, 1));
            bus.out_ready = rdy;
            chk("out_valid", longint'(bus.out_valid), 64'd1);
            chk("out_last", longint'(bus.out_last), longint'(idx == 7));
            chk("out_r", longint'(bus.out_r), longint'(mr[exp_q*8+idx]));
            chk("out_i", longint'(bus.out_i), longint'(mi[exp_q*8+idx]));
            if (rdy) idx++;
            step();
        end
        bus.out_ready = 1'b0;
        chk("handshakes", longint'(idx), 64'd8);
        chk("out_valid_end", longint'(bus.out_valid), 64'd0);
        chk("out_last_end", longint'(bus.out_last), 64'd0);
        chk("select_done", longint'(bus.select_done), 64'd1);
        bus.start = 1'b0;
        step();
        chk("done_cleared", longint'(bus.select_done), 64'd0);
        chk("best_q_held", longint'(bus.best_q), longint'(exp_q));
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.hq_in_valid = 1'b0;
        bus.hq_in_r     = '0;
        bus.hq_in_i     = '0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(bus.out_valid), 64'd0);
        chk("rst_out_last", longint'(bus.out_last), 64'd0);
        chk("rst_out_r", longint'(bus.out_r), 64'd0);
        chk("rst_out_i", longint'(bus.out_i), 64'd0);
        chk("rst_best_q", longint'(bus.best_q), 64'd0);
        chk("rst_best_energy", longint'(bus.best_energy), 64'd0);
        chk("rst_select_done", longint'(bus.select_done), 64'd0);
        rst = 1'b0;
        step();

        // Single stronger matrix among equal ones.
        fill_const(256, 0);
        fill_matrix(5, 512, 0);
        run_job(0, 0);
        chk("t1_q", longint'(bus.best_q), 64'd5);
        chk("t1_e", longint'(bus.best_energy), 64'd2097152);

        // All equal: tie keeps matrix 0.
        fill_const(256, -256);
        run_job(1, 0);
        chk("t2_q", longint'(bus.best_q), 64'd0);
        chk("t2_e", longint'(bus.best_energy), 64'd1048576);

        // Most negative samples: largest possible energy.
        fill_const(1, 1);
        fill_matrix(15, -32768, -32768);
        run_job(0, 2);
        chk("t3_q", longint'(bus.best_q), 64'd15);
        chk("t3_e", longint'(bus.best_energy), 64'd17179869184);

        // Back-to-back stream, matrix 3 strongest, toggled out_ready.
        for (int k = 0; k < 128; k++) begin
            mr[k] = N'($signed($urandom_range(0, 2000)) - 1000);
            mi[k] = N'($signed($urandom_range(0, 2000)) - 1000);
        end
        for (int k = 24; k < 32; k++) begin
            mr[k] = N'($urandom_range(10000, 20000));
            mi[k] = N'($urandom_range(10000, 20000));
            if ($urandom_range(0, 1) != 0) mr[k] = -mr[k];
            if ($urandom_range(0, 1) != 0) mi[k] = -mi[k];
        end
        run_job(0, 1);
        chk("t4_q", longint'(bus.best_q), 64'd3);

        // Fully random jobs.
        repeat (3) begin
            for (int k = 0; k < 128; k++) begin
                mr[k] = N'($urandom);
                mi[k] = N'($urandom);
            end
            run_job(1, 2);
        end

        // Asynchronous reset in the middle of a job after 40 elements.
        for (int k = 0; k < 128; k++) begin
            mr[k] = N'($urandom);
            mi[k] = N'($urandom);
        end
        bus.start = 1'b1;
        step();
        for (int k = 0; k < 40; k++) begin
            bus.hq_in_valid = 1'b1;
            bus.hq_in_r     = mr[k];
            bus.hq_in_i     = mi[k];
            step();
        end
        bus.hq_in_valid = 1'b0;
        ref_best(5);
        chk("pre_rst_q", longint'(bus.best_q), longint'(exp_q));
        chk("pre_rst_e", longint'(bus.best_energy), exp_e);
        #2;
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        chk("arst_best_q", longint'(bus.best_q), 64'd0);
        chk("arst_best_energy", longint'(bus.best_energy), 64'd0);
        chk("arst_out_valid", longint'(bus.out_valid), 64'd0);
        chk("arst_select_done", longint'(bus.select_done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.hq_in_valid = 1'($urandom_range(0, 1));
            bus.hq_in_r     = N'($urandom);
            bus.hq_in_i     = N'($urandom);
            step();
        end
        bus.hq_in_valid = 1'b0;
        chk("idle_best_energy", longint'(bus.best_energy), 64'd0);
        chk("idle_best_q", longint'(bus.best_q), 64'd0);
        chk("idle_out_valid", longint'(bus.out_valid), 64'd0);
        chk("idle_select_done", longint'(bus.select_done), 64'd0);
        fill_const(256, 0);
        fill_matrix(5, 512, 0);
        run_job(1, 1);
        chk("rerun_q", longint'(bus.best_q), 64'd5);
        chk("rerun_e", longint'(bus.best_energy), 64'd2097152);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
